// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the initializer, key scheduler and PRGA stages.
package rc4_pkg;

    localparam int S_SIZE = 256;

    typedef enum logic [3:0] {
        KSA_IDLE,
        KSA_RD_SI,
        KSA_WT_SI,
        KSA_CALC_J,
        KSA_RD_SJ,
        KSA_WT_SJ,
        KSA_WR_SI,
        KSA_WR_SJ,
        KSA_DONE
    } ksa_state_t;

endpackage

// File: rtl/trap_edge.sv
// Rising-edge detector: pulses rise for the cycle in which signal_in is high
// but was low at the previous clock edge.
module trap_edge (
    input  logic clk,
    input  logic reset,
    input  logic signal_in,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= signal_in;
    end

    assign rise = signal_in & ~prev_q;

endmodule

// File: rtl/key_scheduler.sv
// RC4 key-scheduling stage: walks i over the S RAM, accumulates j and swaps
// S[i]/S[j] through the shared single-port RAM master port.
module key_scheduler
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH        = 8,
    parameter int RAM_LENGTH       = 8,
    parameter int KEY_LENGTH       = 3,
    parameter int RAM_READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  secret_key,
    output logic                             finished,
    output logic                             write_enable,
    output logic [RAM_WIDTH-1:0]             ram_in,
    output logic [RAM_LENGTH-1:0]            address,
    input  logic [RAM_WIDTH-1:0]             ram_out
);

    localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam int WAIT_W = (RAM_READ_LATENCY > 1) ? $clog2(RAM_READ_LATENCY) : 1;
    localparam logic [RAM_LENGTH:0]  I_LAST    = {1'b0, {RAM_LENGTH{1'b1}}};
    localparam logic [KIDX_W-1:0]    KIDX_LAST = KIDX_W'(KEY_LENGTH - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(RAM_READ_LATENCY - 1);

    ksa_state_t                      state_q, state_d;
    logic [RAM_LENGTH:0]             i_q, i_d;
    logic [RAM_LENGTH-1:0]           j_q, j_d;
    logic [KIDX_W-1:0]               kidx_q, kidx_d;
    logic [WAIT_W-1:0]               wait_q, wait_d;
    logic [KEY_LENGTH*RAM_WIDTH-1:0] key_q, key_d;
    logic [RAM_WIDTH-1:0]            si_q, si_d, sj_q, sj_d;
    logic [RAM_LENGTH-1:0]           address_q, address_d;
    logic [RAM_WIDTH-1:0]            ram_in_q, ram_in_d;
    logic                            we_q, we_d, fin_q, fin_d;
    logic                            start_rise;

    function automatic logic [RAM_WIDTH-1:0] key_byte(
        input logic [KEY_LENGTH*RAM_WIDTH-1:0] key,
        input logic [KIDX_W-1:0]               k
    );
        logic [RAM_WIDTH-1:0] b;
        b = '0;
        for (int n = 0; n < KEY_LENGTH; n++)
            if (k == KIDX_W'(n)) b = key[(KEY_LENGTH-1-n)*RAM_WIDTH +: RAM_WIDTH];
        return b;
    endfunction

    trap_edge u_start_edge (
        .clk       (clk),
        .reset     (reset),
        .signal_in (start),
        .rise      (start_rise)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        wait_d  = wait_q;
        key_d   = key_q;
        si_d    = si_q;
        sj_d    = sj_q;
        case (state_q)
            KSA_IDLE: if (start_rise) begin
                key_d   = secret_key;
                i_d     = '0;
                j_d     = '0;
                kidx_d  = '0;
                state_d = KSA_RD_SI;
            end
            KSA_RD_SI: begin
                wait_d  = '0;
                state_d = KSA_WT_SI;
            end
            KSA_WT_SI: if (wait_q == WAIT_LAST) begin
                si_d    = ram_out;
                state_d = KSA_CALC_J;
            end else begin
                wait_d  = wait_q + 1'b1;
            end
            KSA_CALC_J: begin
                j_d     = j_q + RAM_LENGTH'(si_q) + RAM_LENGTH'(key_byte(key_q, kidx_q));
                state_d = KSA_RD_SJ;
            end
            KSA_RD_SJ: begin
                wait_d  = '0;
                state_d = KSA_WT_SJ;
            end
            KSA_WT_SJ: if (wait_q == WAIT_LAST) begin
                sj_d    = ram_out;
                state_d = KSA_WR_SI;
            end else begin
                wait_d  = wait_q + 1'b1;
            end
            KSA_WR_SI: state_d = KSA_WR_SJ;
            KSA_WR_SJ: if (i_q == I_LAST) begin
                state_d = KSA_DONE;
            end else begin
                i_d     = i_q + 1'b1;
                kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                state_d = KSA_RD_SI;
            end
            KSA_DONE: state_d = KSA_IDLE;
            default:  state_d = KSA_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        address_d = address_q;
        ram_in_d  = ram_in_q;
        we_d      = 1'b0;
        fin_d     = 1'b0;
        case (state_d)
            KSA_IDLE:  address_d = '0;
            KSA_RD_SI: address_d = i_d[RAM_LENGTH-1:0];
            KSA_RD_SJ: address_d = j_d;
            KSA_WR_SI: begin
                address_d = i_d[RAM_LENGTH-1:0];
                ram_in_d  = sj_d;
                we_d      = 1'b1;
            end
            KSA_WR_SJ: begin
                address_d = j_d;
                ram_in_d  = si_d;
                we_d      = 1'b1;
            end
            KSA_DONE: begin
                address_d = '0;
                fin_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= KSA_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            kidx_q    <= '0;
            wait_q    <= '0;
            address_q <= '0;
            ram_in_q  <= '0;
            we_q      <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            kidx_q    <= kidx_d;
            wait_q    <= wait_d;
            address_q <= address_d;
            ram_in_q  <= ram_in_d;
            we_q      <= we_d;
            fin_q     <= fin_d;
        end
    end

    // Pure data holding registers; every use is qualified by the FSM state.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        si_q  <= si_d;
        sj_q  <= sj_d;
    end

    assign address      = address_q;
    assign ram_in       = ram_in_q;
    assign write_enable = we_q;
    assign finished     = fin_q;

endmodule
